// File: rtl/rr_arb_eight_three.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb_eight_three
// Description : Registered round-robin arbiter sharing one resource among
//               eight requesters. The winner is issued as a one-hot grant and
//               as a 3-bit encoded index that drives the select lines of the
//               downstream shared datapath. A hold limit bounds how long one
//               owner may keep the grant while someone else is waiting.
//
// Ports       : clk        rising-edge system clock
//               rst        synchronous reset, active-high
//               en         arbitration enable (blocks new grants / handoffs)
//               req[7:0]   request vector, bit n = requester n
//               gnt[7:0]   one-hot grant, registered
//               gnt_idx    encoded index of the granted requester, registered
//               gnt_valid  high while a grant is active, registered
//               busy_cnt   cycles the current owner has held the grant, minus 1
//
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb_eight_three #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [7:0]       req,
    output logic [7:0]       gnt,
    output logic [2:0]       gnt_idx,
    output logic             gnt_valid,
    output logic [CNT_W-1:0] busy_cnt
);

    localparam logic [0:0]       c_st_idle   = 1'b0;
    localparam logic [0:0]       c_st_grant  = 1'b1;
    localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] c_busy_max  = {CNT_W{1'b1}};

    logic [0:0]       r_state;
    logic [2:0]       r_last;
    logic [7:0]       r_gnt;
    logic [2:0]       r_idx;
    logic             r_valid;
    logic [CNT_W-1:0] r_busy;

    logic [0:0]       w_state_nxt;
    logic [2:0]       w_last_nxt;
    logic [7:0]       w_gnt_nxt;
    logic [2:0]       w_idx_nxt;
    logic             w_valid_nxt;
    logic [CNT_W-1:0] w_busy_nxt;

    logic [7:0]       w_owner_mask;
    logic             w_others;
    logic             w_release;
    logic [2:0]       w_search_base;
    logic [7:0]       w_cand_req;
    logic [2:0]       w_cand;
    logic             w_win_found;
    logic [2:0]       w_win;

    // ------------------------------------------------------------------------
    // Release detection and round-robin search.
    // In GRANT the search starts just above the current owner, because on a
    // release the owner becomes "last" in the same cycle; the owner's own
    // request is masked so a released owner cannot immediately win again.
    // ------------------------------------------------------------------------
    always_comb begin
        w_owner_mask  = 8'b1 << r_idx;
        w_others      = |(req & ~w_owner_mask);
        // Owner dropping its request takes precedence over a simultaneous
        // timeout; both lead to the same release handling.
        w_release     = (r_state == c_st_grant) &&
                        (!req[r_idx] || ((r_busy == c_hold_last) && w_others));
        w_search_base = (r_state == c_st_grant) ? r_idx : r_last;
        w_cand_req    = (r_state == c_st_grant) ? (req & ~w_owner_mask) : req;

        w_cand      = 3'd0;
        w_win_found = 1'b0;
        w_win       = 3'd0;
        for (int i = 0; i < 8; i++) begin
            // 3-bit arithmetic wraps 7 -> 0 naturally.
            w_cand = w_search_base + 3'd1 + 3'(i);
            if (!w_win_found && w_cand_req[w_cand]) begin
                w_win_found = 1'b1;
                w_win       = w_cand;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_gnt_nxt   = r_gnt;
        w_idx_nxt   = r_idx;
        w_valid_nxt = r_valid;
        w_busy_nxt  = r_busy;

        case (r_state)
            c_st_idle: begin
                if (en && w_win_found) begin
                    w_state_nxt = c_st_grant;
                    w_gnt_nxt   = 8'b1 << w_win;
                    w_idx_nxt   = w_win;
                    w_valid_nxt = 1'b1;
                    w_busy_nxt  = '0;
                end
            end
            c_st_grant: begin
                if (!w_release) begin
                    if (r_busy != c_busy_max) begin
                        w_busy_nxt = r_busy + 1'b1;
                    end
                end else begin
                    w_last_nxt = r_idx;
                    if (en && w_win_found) begin
                        // Direct handoff: no idle bubble between owners.
                        w_gnt_nxt   = 8'b1 << w_win;
                        w_idx_nxt   = w_win;
                        w_valid_nxt = 1'b1;
                        w_busy_nxt  = '0;
                    end else begin
                        // gnt_idx intentionally keeps the previous owner.
                        w_state_nxt = c_st_idle;
                        w_gnt_nxt   = 8'h00;
                        w_valid_nxt = 1'b0;
                        w_busy_nxt  = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_gnt_nxt   = 8'h00;
                w_valid_nxt = 1'b0;
                w_busy_nxt  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and output registers. last resets to 7 so requester 0 is first.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_last  <= 3'd7;
            r_gnt   <= 8'h00;
            r_idx   <= 3'd0;
            r_valid <= 1'b0;
            r_busy  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_gnt   <= w_gnt_nxt;
            r_idx   <= w_idx_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_idx;
    assign gnt_valid = r_valid;
    assign busy_cnt  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb_eight_three.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arb_eight_three
// Description : Directed-vector bench for rr_arb_eight_three. The stimulus
//               process drives one input vector per cycle and queues the
//               hand-derived register contents expected after that edge; a
//               separate monitor pops and compares after every rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arb_eight_three;

    localparam int MAX_HOLD = 4;
    localparam int CNT_W    = 8;

    logic             clk;
    logic             rst;
    logic             en;
    logic [7:0]       req;
    logic [7:0]       gnt;
    logic [2:0]       gnt_idx;
    logic             gnt_valid;
    logic [CNT_W-1:0] busy_cnt;

    typedef struct {
        logic [7:0]       gnt;
        logic [2:0]       idx;
        logic             valid;
        logic [CNT_W-1:0] busy;
        string            name;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run;
    int   tests_failed;

    rr_arb_eight_three #(
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (CNT_W)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .busy_cnt  (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs on the falling edge and queue the values the
    // registers must hold after the following rising edge.
    task automatic step(input logic r, input logic e, input logic [7:0] rq,
                        input logic v, input logic [2:0] idx,
                        input logic [CNT_W-1:0] busy, input string name);
        exp_t x;
        @(negedge clk);
        rst = r;
        en  = e;
        req = rq;
        x.gnt   = v ? (8'b1 << idx) : 8'h00;
        x.idx   = idx;
        x.valid = v;
        x.busy  = busy;
        x.name  = name;
        exp_q.push_back(x);
    endtask

    // Monitor: compare every registered output after each rising edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                tests_run++;
                if (gnt !== x.gnt || gnt_idx !== x.idx ||
                    gnt_valid !== x.valid || busy_cnt !== x.busy) begin
                    tests_failed++;
                    $display("FAIL %s: got gnt=%h idx=%0d valid=%0b busy=%0d, expected gnt=%h idx=%0d valid=%0b busy=%0d",
                             x.name, gnt, gnt_idx, gnt_valid, busy_cnt,
                             x.gnt, x.idx, x.valid, x.busy);
                end
            end
        end
    end

    initial begin
        int wait_cycles;
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b1;
        en  = 1'b0;
        req = 8'h00;

        // Reset for two cycles.
        step(1, 0, 8'h00, 0, 3'd0, 0, "reset0");
        step(1, 0, 8'h00, 0, 3'd0, 0, "reset1");

        // Single request: grant after one edge, released when req drops.
        step(0, 1, 8'h10, 1, 3'd4, 0, "single_grant");
        step(0, 1, 8'h00, 0, 3'd4, 0, "single_release");
        step(0, 1, 8'h00, 0, 3'd4, 0, "single_idle");

        // Full contention from a fresh reset: 0,1,..,7,0,1 each for 4 cycles.
        step(1, 0, 8'h00, 0, 3'd0, 0, "reset_fc");
        for (int j = 0; j < 40; j++) begin
            step(0, 1, 8'hFF, 1, 3'((j / MAX_HOLD) % 8), CNT_W'(j % MAX_HOLD),
                 "full_contention");
        end
        step(0, 1, 8'h00, 0, 3'd1, 0, "fc_release");

        // Wrap-around: owner 6 drops, search wraps 7 -> 0.
        step(0, 1, 8'h40, 1, 3'd6, 0, "wrap_grant6");
        step(0, 1, 8'h41, 1, 3'd6, 1, "wrap_hold1");
        step(0, 1, 8'h41, 1, 3'd6, 2, "wrap_hold2");
        step(0, 1, 8'h01, 1, 3'd0, 0, "wrap_to0");
        step(0, 1, 8'h00, 0, 3'd0, 0, "wrap_release");

        // Sole owner keeps the grant indefinitely; busy_cnt saturates.
        for (int k = 0; k < 300; k++) begin
            step(0, 1, 8'h04, 1, 3'd2, CNT_W'((k > 255) ? 255 : k), "sole_owner");
        end
        step(0, 1, 8'h00, 0, 3'd2, 0, "sole_release");

        // en gating: release with en low goes to IDLE, no handoff.
        step(0, 1, 8'h08, 1, 3'd3, 0, "en_grant3");
        step(0, 0, 8'h0C, 1, 3'd3, 1, "en_low_hold");
        step(0, 0, 8'h04, 0, 3'd3, 0, "en_low_release");
        step(0, 0, 8'h04, 0, 3'd3, 0, "en_low_idle");
        step(0, 1, 8'h04, 1, 3'd2, 0, "en_high_grant2");
        step(0, 1, 8'h00, 0, 3'd2, 0, "en_release");

        // Reset mid-grant: grant drops, priority restarts at requester 0.
        step(0, 1, 8'h21, 1, 3'd5, 0, "mid_grant5");
        step(0, 1, 8'h21, 1, 3'd5, 1, "mid_hold1");
        step(0, 1, 8'h21, 1, 3'd5, 2, "mid_hold2");
        step(1, 1, 8'h21, 0, 3'd0, 0, "mid_reset");
        step(0, 1, 8'h21, 1, 3'd0, 0, "post_reset_grant0");
        step(0, 1, 8'h00, 0, 3'd0, 0, "post_reset_release");

        // Drain the scoreboard with a bounded wait.
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        if (exp_q.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
